// File: rtl/prt_tx_drain.sv
// Read-side drain engine for the Packet Reference Table: opens a slot, streams its
// words out on a registered valid/ready stream with tx_last, then frees the slot.
module prt_tx_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int SLOT_W     = 1,
  parameter int COUNT_W    = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [SLOT_W-1:0]     cmd_slot,
  input  logic                  cmd_drop,
  output logic [SLOT_W-1:0]     start_reading_prt_entry_slot,
  output logic                  EN_start_reading_prt_entry,
  input  logic                  RDY_start_reading_prt_entry,
  output logic                  EN_read_prt_entry,
  input  logic [DATA_WIDTH:0]   read_prt_entry,
  input  logic                  RDY_read_prt_entry,
  output logic [SLOT_W-1:0]     invalidate_prt_entry_slot,
  output logic                  EN_invalidate_prt_entry,
  input  logic                  RDY_invalidate_prt_entry,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  output logic                  tx_last,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic [COUNT_W-1:0]    tx_frame_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_READ,
    S_DRAIN,
    S_INVAL
  } state_t;

  state_t                state_reg;
  logic [SLOT_W-1:0]     slot_reg;
  logic [DATA_WIDTH-1:0] hold_reg;
  logic                  hold_valid_reg;
  logic [DATA_WIDTH-1:0] tx_data_reg;
  logic                  tx_valid_reg;
  logic                  tx_last_reg;
  logic [COUNT_W-1:0]    frame_count_reg;

  logic                  o_free;
  logic                  word_flag;
  logic [DATA_WIDTH-1:0] word_data;

  assign word_flag = read_prt_entry[DATA_WIDTH];
  assign word_data = read_prt_entry[DATA_WIDTH-1:0];

  // The output register can take a new word when it is empty or being consumed now.
  assign o_free = !tx_valid_reg || tx_ready;

  assign cmd_ready                    = (state_reg == S_IDLE);
  assign busy                         = (state_reg != S_IDLE);
  assign EN_start_reading_prt_entry   = (state_reg == S_START) && RDY_start_reading_prt_entry;
  assign EN_read_prt_entry            = (state_reg == S_READ) && RDY_read_prt_entry && o_free;
  assign EN_invalidate_prt_entry      = (state_reg == S_INVAL) && RDY_invalidate_prt_entry;
  assign start_reading_prt_entry_slot = slot_reg;
  assign invalidate_prt_entry_slot    = slot_reg;
  assign tx_data                      = tx_data_reg;
  assign tx_valid                     = tx_valid_reg;
  assign tx_last                      = tx_last_reg;
  assign tx_frame_count               = frame_count_reg;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg       <= S_IDLE;
      slot_reg        <= '0;
      hold_reg        <= '0;
      hold_valid_reg  <= 1'b0;
      tx_data_reg     <= '0;
      tx_valid_reg    <= 1'b0;
      tx_last_reg     <= 1'b0;
      frame_count_reg <= '0;
    end else begin
      if (tx_valid_reg && tx_ready) begin
        tx_valid_reg <= 1'b0;
        tx_last_reg  <= 1'b0;
        if (tx_last_reg) begin
          frame_count_reg <= frame_count_reg + COUNT_W'(1);
        end
      end

      case (state_reg)
        S_IDLE: begin
          if (cmd_valid) begin
            slot_reg  <= cmd_slot;
            state_reg <= cmd_drop ? S_INVAL : S_START;
          end
        end
        S_START: begin
          if (RDY_start_reading_prt_entry) begin
            state_reg <= S_READ;
          end
        end
        S_READ: begin
          // A held word is only released once the following word reveals whether it is last.
          if (EN_read_prt_entry) begin
            if (!word_flag) begin
              if (hold_valid_reg) begin
                tx_data_reg  <= hold_reg;
                tx_valid_reg <= 1'b1;
                tx_last_reg  <= 1'b0;
              end
              hold_reg       <= word_data;
              hold_valid_reg <= 1'b1;
            end else if (hold_valid_reg) begin
              tx_data_reg    <= hold_reg;
              tx_valid_reg   <= 1'b1;
              tx_last_reg    <= 1'b1;
              hold_valid_reg <= 1'b0;
              state_reg      <= S_DRAIN;
            end else begin
              state_reg <= S_INVAL;
            end
          end
        end
        S_DRAIN: begin
          if (o_free) begin
            state_reg <= S_INVAL;
          end
        end
        S_INVAL: begin
          if (RDY_invalidate_prt_entry) begin
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule
